sprite_compositor: RTL and testbench

Parametrised, pipelined replacement for the per-object colour mapping in the tank game. It composites `NUM_SPRITES` square sprites over a background colour for each VGA pixel. Sprite images come from external synchronous frame ROMs, one per channel, and the block aligns pixel coordinates with ROM read latency. Transparent texels fall through to lower-priority sprites and then to the background. A compile-time option adds per-sprite hit-flash blinking. The block sits between the object/position logic and the VGA output pins.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_channel.sv | 84 ++++++++
 rtl/sprite_compositor.sv | 108 ++++++++++
 tb/tb_sprite_compositor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, colour constants and box test for the sprite compositor
package sprite_pkg;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] KEY_COLOR_DEF = 24'hFF0000;
  localparam logic [23:0] BG_COLOR_DEF  = 24'hB7FE7B;
  localparam logic [5:0]  FLASH_LOAD    = 6'd48;

  // Eleven-bit compare so a box hanging past 1023 is clipped rather than wrapped to 0.
  function automatic logic in_box(input coord_t coord, input coord_t origin, input int dim_log2);
    logic [10:0] diff;
    diff = {1'b0, coord} - {1'b0, origin};
    return (coord >= origin) && (diff < (11'd1 << dim_log2));
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// rtl/sprite_channel.sv - per-sprite hit test, ROM address register and optional SPRITE_FLASH_EN blink counter
module sprite_channel
  import sprite_pkg::*;
#(
  parameter int DIM_LOG2 = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
`ifdef SPRITE_FLASH_EN
  input  logic                    frame_start_i,
  input  logic                    flash_req_i,
`endif
  input  logic [9:0]              draw_x_i,
  input  logic [9:0]              draw_y_i,
  input  logic                    en_i,
  input  logic [9:0]              pos_x_i,
  input  logic [9:0]              pos_y_i,
  output logic                    hit_o,
  output logic [2*DIM_LOG2-1:0]   rom_addr_o
);

  localparam int AW = 2 * DIM_LOG2;

  logic [9:0]    off_x, off_y;
  logic          masked;
  logic          hit_d, hit_q;
  logic [AW-1:0] loc_d, loc_q;
  logic [AW-1:0] addr_d, addr_q;

  assign off_x = draw_x_i - pos_x_i;
  assign off_y = draw_y_i - pos_y_i;

`ifdef SPRITE_FLASH_EN
  logic [5:0] flash_d, flash_q;

  // Blink counter: a new request restarts the flash even on a frame boundary.
  always_comb begin
    flash_d = flash_q;
    if (flash_req_i) begin
      flash_d = FLASH_LOAD;
    end else if (frame_start_i && (flash_q != 6'd0)) begin
      flash_d = flash_q - 6'd1;
    end
  end

  // Blink counter register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      flash_q <= 6'd0;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign masked = (flash_q != 6'd0) && flash_q[2];
`else
  assign masked = 1'b0;
`endif

  // Hit test and local texel coordinate for the pixel presented this cycle.
  always_comb begin
    hit_d  = en_i && in_box(draw_x_i, pos_x_i, DIM_LOG2)
                  && in_box(draw_y_i, pos_y_i, DIM_LOG2) && !masked;
    loc_d  = {off_y[DIM_LOG2-1:0], off_x[DIM_LOG2-1:0]};
    addr_d = hit_q ? loc_q : addr_q;
  end

  // Stage the hit, then present the address; misses keep the last address on the ROM.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hit_q  <= 1'b0;
      loc_q  <= '0;
      addr_q <= '0;
    end else begin
      hit_q  <= hit_d;
      loc_q  <= loc_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o      = hit_q;
  assign rom_addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - priority compositing of ROM-backed sprites over a background, SPRITE_FLASH_EN adds hit-flash
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 8,
  parameter int          DIM_LOG2    = 5,
  parameter int          ROM_LATENCY = 1,
  parameter logic [23:0] KEY_COLOR   = KEY_COLOR_DEF,
  parameter logic [23:0] BG_COLOR    = BG_COLOR_DEF
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            pix_valid,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic                            frame_start,
  input  logic [NUM_SPRITES-1:0]          sprite_en,
  input  logic [NUM_SPRITES*10-1:0]       sprite_x,
  input  logic [NUM_SPRITES*10-1:0]       sprite_y,
  input  logic [NUM_SPRITES-1:0]          flash_req,
  output logic [NUM_SPRITES*2*DIM_LOG2-1:0] rom_addr,
  input  logic [NUM_SPRITES*24-1:0]       rom_data,
  output logic                            out_valid,
  output logic [7:0]                      VGA_R,
  output logic [7:0]                      VGA_G,
  output logic [7:0]                      VGA_B
);

  localparam int AW    = 2 * DIM_LOG2;
  localparam int DEPTH = ROM_LATENCY + 1;

  logic [NUM_SPRITES-1:0] hit_a;
  logic                   valid_a_q;
  logic [NUM_SPRITES-1:0] hit_dly_q [DEPTH];
  logic [DEPTH-1:0]       valid_dly_q;
  rgb_t                   pix_d, pix_q;
  logic                   out_valid_q;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
    sprite_channel #(
      .DIM_LOG2(DIM_LOG2)
    ) u_ch (
      .Clk          (Clk),
      .Reset        (Reset),
`ifdef SPRITE_FLASH_EN
      .frame_start_i(frame_start),
      .flash_req_i  (flash_req[i]),
`endif
      .draw_x_i     (DrawX),
      .draw_y_i     (DrawY),
      .en_i         (sprite_en[i]),
      .pos_x_i      (sprite_x[i*10 +: 10]),
      .pos_y_i      (sprite_y[i*10 +: 10]),
      .hit_o        (hit_a[i]),
      .rom_addr_o   (rom_addr[i*AW +: AW])
    );
  end

`ifndef SPRITE_FLASH_EN
  logic unused_flash;
  assign unused_flash = ^{frame_start, flash_req};
`endif

  // Carry hit mask and pixel valid alongside the ROM read so they meet rom_data.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      valid_a_q   <= 1'b0;
      valid_dly_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        hit_dly_q[s] <= '0;
      end
    end else begin
      valid_a_q    <= pix_valid;
      valid_dly_q  <= {valid_dly_q[DEPTH-2:0], valid_a_q};
      hit_dly_q[0] <= hit_a;
      for (int s = 1; s < DEPTH; s++) begin
        hit_dly_q[s] <= hit_dly_q[s-1];
      end
    end
  end

  // Lowest-index opaque texel wins; scanning downward lets it overwrite the others.
  always_comb begin
    pix_d = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_dly_q[DEPTH-1][i] && (rom_data[i*24 +: 24] != KEY_COLOR)) begin
        pix_d = rom_data[i*24 +: 24];
      end
    end
  end

  // Output register; colour is forced to black whenever the pixel is not valid.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_valid_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      out_valid_q <= valid_dly_q[DEPTH-1];
      pix_q       <= valid_dly_q[DEPTH-1] ? pix_d : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign VGA_R     = pix_q.r;
  assign VGA_G     = pix_q.g;
  assign VGA_B     = pix_q.b;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized self-checking bench for sprite_compositor, SPRITE_FLASH_EN adds the flash scenario
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int EM = 8192;

  logic            Clk;
  logic            Reset;
  logic            pix_valid;
  logic [9:0]      DrawX, DrawY;
  logic            frame_start;
  logic [N-1:0]    sprite_en;
  logic [N*10-1:0] sprite_x, sprite_y;
  logic [N-1:0]    flash_req;
  logic [N*AW-1:0] rom_addr;
  logic [N*24-1:0] rom_data;
  logic            out_valid;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  logic [23:0] tex [N][1024];
  logic [24:0] exp_mem [EM];
  logic [N-1:0] hid;
  int flash_cnt [N];
  int cyc, n_checks, n_pass;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .sprite_en(sprite_en), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .flash_req(flash_req), .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous frame ROMs with one cycle of read latency.
  always @(posedge Clk) begin
    for (int i = 0; i < N; i++) begin
      rom_data[i*24 +: 24] <= tex[i][rom_addr[i*AW +: AW]];
    end
  end

  function automatic logic [23:0] model_px(input int x, input int y);
    int sx, sy, a;
    for (int i = 0; i < N; i++) begin
      sx = int'(sprite_x[i*10 +: 10]);
      sy = int'(sprite_y[i*10 +: 10]);
      if (sprite_en[i] && !hid[i] && x >= sx && x - sx < 32 && y >= sy && y - sy < 32) begin
        a = (y - sy) * 32 + (x - sx);
        if (tex[i][a] != KEY_COLOR_DEF) return tex[i][a];
      end
    end
    return BG_COLOR_DEF;
  endfunction

  task automatic drive_px(input int x, input int y, input logic v);
    int xx, yy;
    xx = x & 1023;
    yy = y & 1023;
    DrawX = 10'(xx);
    DrawY = 10'(yy);
    pix_valid = v;
    hid = '0;
`ifdef SPRITE_FLASH_EN
    for (int i = 0; i < N; i++) hid[i] = (flash_cnt[i] != 0) && (((flash_cnt[i] >> 2) & 1) == 1);
    for (int i = 0; i < N; i++) begin
      if (!Reset) flash_cnt[i] = 0;
      else if (flash_req[i]) flash_cnt[i] = 48;
      else if (frame_start && flash_cnt[i] > 0) flash_cnt[i] = flash_cnt[i] - 1;
    end
`endif
    exp_mem[cyc % EM] = v ? {1'b1, model_px(xx, yy)} : 25'd0;
    if (!Reset) begin
      for (int j = 0; j < 4; j++) if (cyc >= j) exp_mem[(cyc - j) % EM] = 25'd0;
    end
    @(negedge Clk);
    cyc++;
  endtask

  task automatic fill_tex(input int key_pct);
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 1024; a++)
        tex[i][a] = ($urandom_range(0, 99) < key_pct) ? KEY_COLOR_DEF : 24'($urandom);
  endtask

  task automatic place(input int ch, input int x, input int y);
    sprite_x[ch*10 +: 10] = 10'(x);
    sprite_y[ch*10 +: 10] = 10'(y);
  endtask

  task automatic reposition();
    int base_x, base_y;
    base_x = $urandom_range(0, 1023);
    base_y = $urandom_range(0, 1023);
    for (int i = 0; i < N; i++) place(i, (base_x + $urandom_range(0, 40)) & 1023, (base_y + $urandom_range(0, 40)) & 1023);
    sprite_en = N'($urandom);
  endtask

  task automatic pick_px(output int x, output int y, output logic v);
    int c;
    c = $urandom_range(0, N - 1);
    x = int'(sprite_x[c*10 +: 10]) + int'($urandom_range(0, 40)) - 4;
    y = int'(sprite_y[c*10 +: 10]) + int'($urandom_range(0, 40)) - 4;
    v = ($urandom_range(0, 7) != 0);
  endtask

  task automatic test_reset();
    Reset = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0; frame_start = 1'b0;
    sprite_en = '0; sprite_x = '0; sprite_y = '0; flash_req = '0;
    for (int n = 0; n < 4; n++) drive_px(0, 0, 1'b0);
    n_checks++;
    if ({out_valid, VGA_R, VGA_G, VGA_B} !== 25'd0) $display("FAIL reset_out got %h expected 0", {out_valid, VGA_R, VGA_G, VGA_B});
    else n_pass++;
    n_checks++;
    if (rom_addr !== '0) $display("FAIL reset_rom_addr got %h expected 0", rom_addr);
    else n_pass++;
    Reset = 1'b1;
    drive_px(0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %b expected 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    sprite_en = 8'h01;
    place(0, 100, 50);
    tex[0][10'h065] = 24'h123456;
    for (int n = 0; n < 6; n++) begin
      drive_px(n == 0 ? 105 : 0, n == 0 ? 53 : 0, n == 0);
      n_checks++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
        $display("FAIL single_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
      else n_pass++;
      if (n == 1) begin
        n_checks++;
        if (rom_addr[9:0] !== 10'h065) $display("FAIL single_rom_addr got %h expected 065", rom_addr[9:0]);
        else n_pass++;
      end
      if (n == 3) begin
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, 24'h123456})
          $display("FAIL single_pixel got %h expected 1123456", {out_valid, VGA_R, VGA_G, VGA_B});
        else n_pass++;
      end
    end
  endtask

  task automatic test_transparency();
    logic [23:0] want;
    sprite_en = 8'h03;
    place(0, 0, 0);
    place(1, 0, 0);
    tex[1][132] = 24'h00FF00;
    for (int ph = 0; ph < 2; ph++) begin
      tex[0][132] = (ph == 0) ? KEY_COLOR_DEF : 24'h0000FF;
      want        = (ph == 0) ? 24'h00FF00 : 24'h0000FF;
      for (int n = 0; n < 6; n++) begin
        drive_px(n == 0 ? 4 : 900, n == 0 ? 4 : 900, n == 0);
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
          $display("FAIL transp_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
        else n_pass++;
        if (n == 3) begin
          n_checks++;
          if ({out_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, want})
            $display("FAIL transp_pixel ph=%0d got %h expected %h", ph, {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, want});
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_boundary();
    int px [6] = '{1023, 0, 132, 131, 1000, 1000};
    int py [6] = '{0, 0, 0, 0, 31, 32};
    logic [23:0] pe [6] = '{24'hABCDEF, BG_COLOR_DEF, BG_COLOR_DEF, 24'h010203, 24'h445566, BG_COLOR_DEF};
    sprite_en = 8'h03;
    place(0, 1000, 0);
    place(1, 100, 0);
    tex[0][23]  = 24'hABCDEF;
    tex[0][992] = 24'h445566;
    tex[1][31]  = 24'h010203;
    for (int n = 0; n < 10; n++) begin
      if (n < 6) drive_px(px[n], py[n], 1'b1);
      else drive_px(500, 500, 1'b0);
      n_checks++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
        $display("FAIL bound_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
      else n_pass++;
      if (n >= 3 && n < 9) begin
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, pe[n-3]})
          $display("FAIL bound_pixel idx=%0d got %h expected %h", n - 3, {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, pe[n-3]});
        else n_pass++;
      end
    end
  endtask

  task automatic test_disabled();
    sprite_en = 8'h00;
    place(0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      drive_px($urandom_range(0, 31), $urandom_range(0, 31), n < 8);
      n_checks++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
        $display("FAIL disabled_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
      else n_pass++;
      if (n >= 3 && n < 11) begin
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== {1'b1, BG_COLOR_DEF})
          $display("FAIL disabled_bg got %h expected %h", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, BG_COLOR_DEF});
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int x, y;
    logic v;
    reposition();
    for (int n = 0; n < 604; n++) begin
      if ($urandom_range(0, 15) == 0) reposition();
      pick_px(x, y, v);
      drive_px(x, y, (n < 600) ? v : 1'b0);
      n_checks++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
        $display("FAIL b2b_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    int x, y;
    logic v;
    reposition();
    sprite_en = '1;
    for (int n = 0; n < 44; n++) begin
      pick_px(x, y, v);
      if (n >= 14 && n < 26) v = 1'b1;
      if (n >= 40) v = 1'b0;
      if (n == 20) Reset = 1'b0;
      drive_px(x, y, v);
      Reset = 1'b1;
      n_checks++;
      if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
        $display("FAIL rstmid_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
      else n_pass++;
      if (n >= 20 && n <= 22) begin
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== 25'd0)
          $display("FAIL rstmid_flushed n=%0d got %h expected 0", n, {out_valid, VGA_R, VGA_G, VGA_B});
        else n_pass++;
      end
      if (n == 24) begin
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL rstmid_resume got %b expected 1", out_valid);
        else n_pass++;
      end
    end
  endtask

`ifdef SPRITE_FLASH_EN
  task automatic test_flash();
    int hidden_seen;
    hidden_seen = 0;
    sprite_en = 8'h01;
    place(0, 10, 10);
    tex[0][0] = 24'h00AA00;
    flash_req = 8'h01;
    drive_px(0, 0, 1'b0);
    flash_req = '0;
    for (int f = 0; f < 54; f++) begin
      for (int k = 0; k < 2; k++) begin
        frame_start = (k == 1);
        drive_px(10, 10, k == 0 && f < 52);
        frame_start = 1'b0;
        n_checks++;
        if ({out_valid, VGA_R, VGA_G, VGA_B} !== exp_mem[(cyc - 4) % EM])
          $display("FAIL flash_stream cyc=%0d got %h expected %h", cyc, {out_valid, VGA_R, VGA_G, VGA_B}, exp_mem[(cyc - 4) % EM]);
        else n_pass++;
        if (out_valid === 1'b1 && {VGA_R, VGA_G, VGA_B} === BG_COLOR_DEF) hidden_seen++;
      end
    end
    n_checks++;
    if (hidden_seen != 24) $display("FAIL flash_hidden_frames got %0d expected 24", hidden_seen);
    else n_pass++;
  endtask
`endif

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    for (int i = 0; i < N; i++) flash_cnt[i] = 0;
    fill_tex(25);
    test_reset();
    test_single();
    test_transparency();
    test_boundary();
    test_disabled();
    test_back_to_back();
    test_reset_midstream();
`ifdef SPRITE_FLASH_EN
    test_flash();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
